// File: rtl/mac_tree_ctrl.sv
// Job sequencer for the 8-lane fp32 MAC tree: clears accumulators, streams gated operands,
// waits out the pipeline drain and presents the result. Optional perf counters: MAC_TREE_CTRL_PERF_EN.
module mac_tree_ctrl #(
    parameter int CLR_CYCLES   = 4,
    parameter int DRAIN_CYCLES = 24,
    parameter int BEAT_W       = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [255:0]      in_a,
    input  logic [255:0]      in_b,
    input  logic              in_valid,
    input  logic              in_last,
    output logic              in_ready,
    output logic [255:0]      mac_a,
    output logic [255:0]      mac_b,
    output logic              mac_rst,
    input  logic [31:0]       mac_out,
    output logic [31:0]       res_data,
    output logic [BEAT_W-1:0] res_beats,
    output logic              res_valid,
    input  logic              res_ready
`ifdef MAC_TREE_CTRL_PERF_EN
    ,
    output logic [31:0]       perf_cycles,
    output logic [31:0]       stall_cycles
`endif
);

    localparam int CLR_W = (CLR_CYCLES > 1) ? $clog2(CLR_CYCLES) : 1;
    localparam int DRN_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        STREAM,
        DRAIN,
        HOLD
    } state_t;

    state_t            state_reg;
    logic [CLR_W-1:0]  clr_cnt_reg;
    logic [DRN_W-1:0]  drn_cnt_reg;
    logic [BEAT_W-1:0] beat_cnt_reg;
    logic              in_ready_reg;
    logic              mac_rst_reg;
    logic              res_valid_reg;
    logic [31:0]       res_data_reg;
    logic [BEAT_W-1:0] res_beats_reg;

    logic              accept;
    logic              leave_idle;
    logic              drain_done;
    logic [BEAT_W-1:0] beat_inc;
    logic              beat_final;

    assign accept     = in_valid && in_ready_reg;
    assign leave_idle = (state_reg == IDLE) && in_valid;
    assign drain_done = (state_reg == DRAIN) && (drn_cnt_reg == '0);
    assign beat_inc   = (beat_cnt_reg == '1) ? beat_cnt_reg : beat_cnt_reg + 1'b1;
    // The beat that fills the counter ends the job, capping jobs at 2^BEAT_W-1 beats.
    assign beat_final = in_last || (beat_inc == '1);

    assign in_ready  = in_ready_reg;
    assign mac_rst   = mac_rst_reg;
    assign res_valid = res_valid_reg;
    assign res_data  = res_data_reg;
    assign res_beats = res_beats_reg;

    // Operands are zero on every cycle without an accepted beat so the free-running accumulators hold.
    for (genvar gi = 0; gi < 8; gi++) begin : g_lane
        logic [31:0] a_reg;
        logic [31:0] b_reg;
        always_ff @(posedge clk) begin
            if (rst) begin
                a_reg <= '0;
                b_reg <= '0;
            end else begin
                a_reg <= accept ? in_a[gi*32 +: 32] : 32'd0;
                b_reg <= accept ? in_b[gi*32 +: 32] : 32'd0;
            end
        end
        assign mac_a[gi*32 +: 32] = a_reg;
        assign mac_b[gi*32 +: 32] = b_reg;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= IDLE;
            clr_cnt_reg   <= '0;
            drn_cnt_reg   <= '0;
            beat_cnt_reg  <= '0;
            in_ready_reg  <= 1'b0;
            mac_rst_reg   <= 1'b1;
            res_valid_reg <= 1'b0;
            res_data_reg  <= '0;
            res_beats_reg <= '0;
        end else begin
            unique case (state_reg)
                IDLE: begin
                    if (in_valid) begin
                        state_reg   <= CLEAR;
                        clr_cnt_reg <= CLR_W'(CLR_CYCLES - 1);
                    end
                end
                CLEAR: begin
                    if (clr_cnt_reg == '0) begin
                        state_reg    <= STREAM;
                        beat_cnt_reg <= '0;
                        in_ready_reg <= 1'b1;
                        mac_rst_reg  <= 1'b0;
                    end else begin
                        clr_cnt_reg <= clr_cnt_reg - 1'b1;
                    end
                end
                STREAM: begin
                    if (accept) begin
                        beat_cnt_reg <= beat_inc;
                        if (beat_final) begin
                            state_reg    <= DRAIN;
                            drn_cnt_reg  <= DRN_W'(DRAIN_CYCLES - 1);
                            in_ready_reg <= 1'b0;
                        end
                    end
                end
                DRAIN: begin
                    if (drn_cnt_reg == '0) begin
                        state_reg     <= HOLD;
                        res_data_reg  <= mac_out;
                        res_beats_reg <= beat_cnt_reg;
                        res_valid_reg <= 1'b1;
                    end else begin
                        drn_cnt_reg <= drn_cnt_reg - 1'b1;
                    end
                end
                HOLD: begin
                    if (res_ready) begin
                        state_reg     <= IDLE;
                        res_valid_reg <= 1'b0;
                        mac_rst_reg   <= 1'b1;
                    end
                end
                default: begin
                    state_reg    <= IDLE;
                    in_ready_reg <= 1'b0;
                    mac_rst_reg  <= 1'b1;
                end
            endcase
        end
    end

`ifdef MAC_TREE_CTRL_PERF_EN
    logic [31:0] perf_run_reg;
    logic [31:0] perf_cycles_reg;
    logic [31:0] stall_cycles_reg;
    logic [31:0] perf_inc;
    logic        job_active;

    assign perf_inc   = (perf_run_reg == '1) ? perf_run_reg : perf_run_reg + 32'd1;
    assign job_active = (state_reg == CLEAR) || (state_reg == STREAM) || (state_reg == DRAIN);

    always_ff @(posedge clk) begin
        if (rst || leave_idle) begin
            perf_run_reg     <= '0;
            perf_cycles_reg  <= '0;
            stall_cycles_reg <= '0;
        end else begin
            if (job_active) begin
                perf_run_reg <= perf_inc;
            end
            if (drain_done) begin
                perf_cycles_reg <= perf_inc;
            end
            if ((state_reg == STREAM) && !in_valid && (stall_cycles_reg != '1)) begin
                stall_cycles_reg <= stall_cycles_reg + 32'd1;
            end
        end
    end

    assign perf_cycles  = perf_cycles_reg;
    assign stall_cycles = stall_cycles_reg;
`else
    logic unused_drain_done;
    assign unused_drain_done = leave_idle ^ drain_done;
`endif

endmodule
